// File: rtl/decode_alu_stage.sv
// decode_alu_stage
// Execute stage for a 32-bit MIPS subset. Decodes the instruction word,
// extends imm16, picks the ALU B operand and registers the ALU result and
// flags (one cycle of latency). Decode, extend and operand selection are
// combinational.
//
// Ports
//   CLK, RST_N        rising-edge clock, asynchronous active-low reset
//   instr             instruction word
//   busA, busB        rs / rt operands from the register file
//   rs, rt, rd, shamt instruction register and shift-amount fields
//   imm16, instr_index immediate and jump-target fields
//   rw                destination register (rd for R-type, rt otherwise)
//   reg_dst .. alu_src decoded control bits
//   alu_ctr           decoded ALU operation
//   imm32             extended immediate
//   result            registered ALU result
//   v, c_out, zero    registered overflow, carry/no-borrow, result==0
module decode_alu_stage (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] instr,
    input  logic [31:0] busA,
    input  logic [31:0] busB,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] imm16,
    output logic [25:0] instr_index,
    output logic [4:0]  rw,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        jump,
    output logic        branch,
    output logic        sign_ext,
    output logic        alu_src,
    output logic [3:0]  alu_ctr,
    output logic [31:0] imm32,
    output logic [31:0] result,
    output logic        v,
    output logic        c_out,
    output logic        zero
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADDU = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SUBU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SLL  = 4'd10;
    localparam logic [3:0] ALU_SRL  = 4'd11;
    localparam logic [3:0] ALU_SRA  = 4'd12;
    localparam logic [3:0] ALU_LUI  = 4'd13;

    logic [5:0] op;
    logic [5:0] funct;

    assign op          = instr[31:26];
    assign funct       = instr[5:0];
    assign rs          = instr[25:21];
    assign rt          = instr[20:16];
    assign rd          = instr[15:11];
    assign shamt       = instr[10:6];
    assign imm16       = instr[15:0];
    assign instr_index = instr[25:0];
    assign rw          = reg_dst ? rd : rt;
    assign imm32       = sign_ext ? {{16{imm16[15]}}, imm16} : {16'h0000, imm16};

    always_comb begin
        reg_dst   = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        jump      = 1'b0;
        branch    = 1'b0;
        sign_ext  = 1'b0;
        alu_src   = 1'b0;
        alu_ctr   = ALU_ADD;
        case (op)
            6'h00: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                case (funct)
                    6'h20: alu_ctr = ALU_ADD;
                    6'h21: alu_ctr = ALU_ADDU;
                    6'h22: alu_ctr = ALU_SUB;
                    6'h23: alu_ctr = ALU_SUBU;
                    6'h24: alu_ctr = ALU_AND;
                    6'h25: alu_ctr = ALU_OR;
                    6'h26: alu_ctr = ALU_XOR;
                    6'h27: alu_ctr = ALU_NOR;
                    6'h2A: alu_ctr = ALU_SLT;
                    6'h2B: alu_ctr = ALU_SLTU;
                    6'h00: alu_ctr = ALU_SLL;
                    6'h02: alu_ctr = ALU_SRL;
                    6'h03: alu_ctr = ALU_SRA;
                    default: begin
                        // unsupported funct behaves as a NOP
                        reg_dst   = 1'b0;
                        reg_write = 1'b0;
                        alu_ctr   = ALU_ADD;
                    end
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                sign_ext  = 1'b1;
                case (op[1:0])
                    2'd0:    alu_ctr = ALU_ADD;
                    2'd1:    alu_ctr = ALU_ADDU;
                    2'd2:    alu_ctr = ALU_SLT;
                    default: alu_ctr = ALU_SLTU;
                endcase
            end
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                case (op[1:0])
                    2'd0:    alu_ctr = ALU_AND;
                    2'd1:    alu_ctr = ALU_OR;
                    2'd2:    alu_ctr = ALU_XOR;
                    default: alu_ctr = ALU_LUI;
                endcase
            end
            6'h23: begin
                alu_ctr   = ALU_ADDU;
                sign_ext  = 1'b1;
                alu_src   = 1'b1;
                mem_read  = 1'b1;
                reg_write = 1'b1;
            end
            6'h2B: begin
                alu_ctr   = ALU_ADDU;
                sign_ext  = 1'b1;
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            6'h04, 6'h05: begin
                alu_ctr  = ALU_SUB;
                branch   = 1'b1;
                sign_ext = 1'b1;
            end
            6'h02: jump = 1'b1;
            default: ;
        endcase
    end

    logic [31:0] op_b;
    logic [32:0] sum;
    logic [32:0] diff;
    logic [31:0] alu_res;
    logic        alu_v;
    logic        alu_c;

    assign op_b = alu_src ? imm32 : busB;
    assign sum  = {1'b0, busA} + {1'b0, op_b};
    // diff[32] is the borrow; no borrow means busA >= op_b unsigned
    assign diff = {1'b0, busA} - {1'b0, op_b};

    always_comb begin
        alu_res = 32'h0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        case (alu_ctr)
            ALU_ADD: begin
                alu_res = sum[31:0];
                alu_c   = sum[32];
                alu_v   = (busA[31] == op_b[31]) && (sum[31] != busA[31]);
            end
            ALU_ADDU: begin
                alu_res = sum[31:0];
                alu_c   = sum[32];
            end
            ALU_SUB: begin
                alu_res = diff[31:0];
                alu_c   = ~diff[32];
                alu_v   = (busA[31] != op_b[31]) && (diff[31] != busA[31]);
            end
            ALU_SUBU: begin
                alu_res = diff[31:0];
                alu_c   = ~diff[32];
            end
            ALU_AND:  alu_res = busA & op_b;
            ALU_OR:   alu_res = busA | op_b;
            ALU_XOR:  alu_res = busA ^ op_b;
            ALU_NOR:  alu_res = ~(busA | op_b);
            ALU_SLT:  alu_res = {31'h0, $signed(busA) < $signed(op_b)};
            ALU_SLTU: alu_res = {31'h0, busA < op_b};
            ALU_SLL:  alu_res = op_b << shamt;
            ALU_SRL:  alu_res = op_b >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(op_b) >>> shamt);
            ALU_LUI:  alu_res = op_b << 16;
            default:  alu_res = 32'h0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            result <= 32'h0;
            v      <= 1'b0;
            c_out  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            result <= alu_res;
            v      <= alu_v;
            c_out  <= alu_c;
            zero   <= (alu_res == 32'h0);
        end
    end

endmodule

// File: tb/tb_decode_alu_stage.sv
module tb_decode_alu_stage;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] instr;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [4:0]  rs, rt, rd, shamt, rw;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic        reg_dst, reg_write, mem_read, mem_write, jump, branch, sign_ext, alu_src;
    logic [3:0]  alu_ctr;
    logic [31:0] imm32;
    logic [31:0] result;
    logic        v, c_out, zero;

    int checks   = 0;
    int failures = 0;

    decode_alu_stage dut (
        .CLK(CLK), .RST_N(RST_N), .instr(instr), .busA(busA), .busB(busB),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm16(imm16),
        .instr_index(instr_index), .rw(rw),
        .reg_dst(reg_dst), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .jump(jump), .branch(branch),
        .sign_ext(sign_ext), .alu_src(alu_src), .alu_ctr(alu_ctr),
        .imm32(imm32), .result(result), .v(v), .c_out(c_out), .zero(zero)
    );

    always #5 CLK = ~CLK;

    logic [7:0] ctrl;
    logic [2:0] flags;
    assign ctrl  = {reg_dst, reg_write, mem_read, mem_write, jump, branch, sign_ext, alu_src};
    assign flags = {v, c_out, zero};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive inputs just after a rising edge, then sample 1 unit after the next one
    task automatic step(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        instr = i;
        busA  = a;
        busB  = b;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0;
        instr = 32'h0;
        busA  = 32'h0;
        busB  = 32'h0;
        #2;
        check("reset_result", result, 32'h0);
        check("reset_flags", {29'h0, flags}, 32'h0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // add $3,$1,$2 : signed overflow
        step(32'h00221820, 32'h7FFFFFFF, 32'h1);
        check("add_result", result, 32'h80000000);
        check("add_flags", {29'h0, flags}, 32'b100);
        check("add_rw", {27'h0, rw}, 32'd3);
        check("add_ctrl", {20'h0, ctrl, alu_ctr}, {20'h0, 8'b1100_0000, 4'd0});

        // subu equal / underflow
        step(32'h00221823, 32'h5, 32'h5);
        check("subu_eq_result", result, 32'h0);
        check("subu_eq_flags", {29'h0, flags}, 32'b011);
        step(32'h00221823, 32'h0, 32'h1);
        check("subu_lt_result", result, 32'hFFFFFFFF);
        check("subu_lt_flags", {29'h0, flags}, 32'b000);

        // addi $2,$1,-1
        step(32'h2022FFFF, 32'h1, 32'h12345678);
        check("addi_result", result, 32'h0);
        check("addi_zero", {31'h0, zero}, 32'h1);
        check("addi_imm32", imm32, 32'hFFFFFFFF);
        check("addi_rw", {27'h0, rw}, 32'd2);
        check("addi_ctrl", {20'h0, ctrl, alu_ctr}, {20'h0, 8'b0100_0011, 4'd0});

        // ori $2,$1,0xFFFF : zero extension
        step(32'h3422FFFF, 32'h0, 32'hAAAAAAAA);
        check("ori_result", result, 32'h0000FFFF);
        check("ori_imm32", imm32, 32'h0000FFFF);
        check("ori_ctrl", {20'h0, ctrl, alu_ctr}, {20'h0, 8'b0100_0001, 4'd5});

        // sra / srl by 4
        step(32'h00021903, 32'h0, 32'h80000000);
        check("sra_result", result, 32'hF8000000);
        check("sra_shamt", {27'h0, shamt}, 32'd4);
        step(32'h00021902, 32'h0, 32'h80000000);
        check("srl_result", result, 32'h08000000);

        // lui $2,0x1234
        step(32'h3C021234, 32'hFFFFFFFF, 32'h0);
        check("lui_result", result, 32'h12340000);
        check("lui_ctrl", {20'h0, ctrl, alu_ctr}, {20'h0, 8'b0100_0001, 4'd13});

        // lw / sw address arithmetic
        step(32'h8C220004, 32'h00001000, 32'h0);
        check("lw_ctrl", {20'h0, ctrl, alu_ctr}, {20'h0, 8'b0110_0011, 4'd1});
        check("lw_result", result, 32'h00001004);
        step(32'hAC22FFFC, 32'h00001000, 32'h0);
        check("sw_ctrl", {20'h0, ctrl, alu_ctr}, {20'h0, 8'b0001_0011, 4'd1});
        check("sw_result", result, 32'h00000FFC);

        // beq with equal operands
        step(32'h10220003, 32'h9, 32'h9);
        check("beq_ctrl", {20'h0, ctrl, alu_ctr}, {20'h0, 8'b0000_0110, 4'd2});
        check("beq_flags", {29'h0, flags}, 32'b011);

        // j
        step(32'h08000010, 32'h0, 32'h0);
        check("j_ctrl", {20'h0, ctrl, alu_ctr}, {20'h0, 8'b0000_1000, 4'd0});
        check("j_index", {6'h0, instr_index}, 32'h0000010);

        // undefined opcode 3F
        step(32'hFC000000, 32'h1, 32'h2);
        check("undef_ctrl", {20'h0, ctrl, alu_ctr}, 32'h0);

        // slt / sltu with A=-1, B=1
        step(32'h0022182A, 32'hFFFFFFFF, 32'h1);
        check("slt_result", result, 32'h1);
        step(32'h0022182B, 32'hFFFFFFFF, 32'h1);
        check("sltu_result", result, 32'h0);

        // all-zero word: sll by 0 writing $0
        step(32'h00000000, 32'h0, 32'hDEADBEEF);
        check("nop_ctrl", {20'h0, ctrl, alu_ctr}, {20'h0, 8'b1100_0000, 4'd10});
        check("nop_result", result, 32'hDEADBEEF);

        // asynchronous reset between edges, decode stays live
        step(32'h00221820, 32'h7FFFFFFF, 32'h1);
        check("pre_rst_result", result, 32'h80000000);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_result", result, 32'h0);
        check("async_rst_flags", {29'h0, flags}, 32'h0);
        check("async_rst_rw", {27'h0, rw}, 32'd3);
        RST_N = 1'b1;
        #1;
        check("rst_release_hold", result, 32'h0);
        @(posedge CLK);
        #1;
        check("rst_release_load", result, 32'h80000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
